concat_select_pipe: RTL and testbench

Pipelined, parametrised select-and-concatenate datapath for CH equal-width input channels. A selected channel acts as both the condition and the true operand: if it is nonzero it is sign- or zero-extended, otherwise a constant is ORed with the next channel. The result is truncated to a body field and prefixed with a constant header. The block sits between a valid/ready producer and consumer. It carries a per-transaction sequence tag, has 2-stage latency, and sustains one result per clock.

---
 rtl/concat_select_pipe.sv | 185 ++++++++++++++++++
 tb/tb_concat_select_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/concat_select_pipe.sv
`default_nettype none
// ============================================================================
// Module      : concat_select_pipe
// Description : Two-stage select-and-concatenate datapath with valid/ready
//               handshake on both sides and a per-transaction sequence tag.
//               Stage 1 captures the selected channel (a), its neighbour (b),
//               the condition (a != 0) and the tag. Stage 2 builds the body
//               (extended a, or OR_CONST | b), truncates it to BODY_W bits and
//               prefixes the constant header into the output register.
// Ports       :
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   producer has data
//   in_ready   out  block accepts this cycle (combinational on out_ready)
//   in_data    in   CH channels, channel c at [c*W +: W]
//   sel_ch     in   operand channel select, wraps modulo CH
//   out_valid  out  result available
//   out_ready  in   consumer accepts
//   out_data   out  {header, body}
//   out_tag    out  sequence number of this result
// Revision    : 1.0  initial release
// ============================================================================
module concat_select_pipe #(
    parameter int CH          = 4,
    parameter int W           = 13,
    parameter int HDR_W       = 10,
    parameter     HDR         = 10'h001,
    parameter int W_OUT       = 24,
    parameter     OR_CONST    = 22'hd,
    parameter int SIGNED_MODE = 1,
    parameter int TAG_W       = 8,
    localparam int SEL_W      = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*W-1:0]     in_data,
    input  logic [SEL_W-1:0]    sel_ch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W_OUT-1:0]    out_data,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int BODY_W = W_OUT - HDR_W;
    // Common width for both branches so the true operand can be extended
    // before truncation even when W exceeds BODY_W.
    localparam int EXT_W  = (W > BODY_W) ? W : BODY_W;

    localparam logic [HDR_W-1:0]  C_HDR = HDR_W'(HDR);
    localparam logic [BODY_W-1:0] C_OR  = BODY_W'(OR_CONST);

    // ------------------------------------------------------------------
    // Channel unpacking and operand selection
    // ------------------------------------------------------------------
    logic [W-1:0] w_ch [CH];

    for (genvar c = 0; c < CH; c++) begin : g_unpack
        assign w_ch[c] = in_data[c*W +: W];
    end

    logic [SEL_W-1:0] w_idx_a;
    logic [SEL_W-1:0] w_idx_b;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;

    // Modulo keeps out-of-range selects legal when CH is not a power of two.
    always_comb begin
        w_idx_a = SEL_W'(32'(sel_ch) % 32'(CH));
        w_idx_b = SEL_W'((32'(w_idx_a) + 32'd1) % 32'(CH));
        w_a     = w_ch[w_idx_a];
        w_b     = w_ch[w_idx_b];
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;

    logic w_s2_load_en;
    logic w_in_fire;

    assign w_s2_load_en = !out_valid_q || out_ready;
    assign in_ready     = !s1_valid_q || w_s2_load_en;
    assign w_in_fire    = in_valid && in_ready;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]     s1_a_q,    s1_a_d;
    logic [W-1:0]     s1_b_q,    s1_b_d;
    logic             s1_cond_q, s1_cond_d;
    logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    logic [W_OUT-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q,  out_tag_d;

    // ------------------------------------------------------------------
    // Stage 2 body computation from the s1 registers
    // ------------------------------------------------------------------
    logic [EXT_W-1:0]  w_true;
    logic [EXT_W-1:0]  w_false;
    logic [BODY_W-1:0] w_body;

    always_comb begin
        if (SIGNED_MODE != 0) begin
            w_true = EXT_W'($signed(s1_a_q));
        end else begin
            w_true = EXT_W'(s1_a_q);
        end
        w_false = EXT_W'(s1_b_q) | EXT_W'(C_OR);
        // Truncation to the body field is intentionally silent.
        w_body  = s1_cond_q ? w_true[BODY_W-1:0] : w_false[BODY_W-1:0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cond_d   = s1_cond_q;
        s1_tag_d    = s1_tag_q;
        tag_cnt_d   = tag_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;

        // Stage 1: a new capture wins over draining, which covers the
        // simultaneous advance-and-refill case without a bubble.
        if (w_in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = w_a;
            s1_b_d     = w_b;
            s1_cond_d  = (w_a != '0);
            s1_tag_d   = tag_cnt_q;
            tag_cnt_d  = tag_cnt_q + TAG_W'(1);
        end else if (s1_valid_q && w_s2_load_en) begin
            s1_valid_d = 1'b0;
        end

        // Stage 2: the output register only changes when it is empty or
        // being drained, so data and tag hold during a stall.
        if (w_s2_load_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = {C_HDR, w_body};
                out_tag_d  = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cond_q   <= 1'b0;
            s1_tag_q    <= '0;
            tag_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cond_q   <= s1_cond_d;
            s1_tag_q    <= s1_tag_d;
            tag_cnt_q   <= tag_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_concat_select_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_concat_select_pipe
// Description : Directed self-checking bench for concat_select_pipe. A second
//               instance with SIGNED_MODE=0 shares the stimulus so the
//               zero-extend variant can be checked alongside.
// Revision    : 1.0  initial release
// ============================================================================
module tb_concat_select_pipe;

    localparam int CH    = 4;
    localparam int W     = 13;
    localparam int W_OUT = 24;
    localparam int TAG_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CH*W-1:0]   in_data;
    logic [1:0]        sel_ch;
    logic              out_valid;
    logic              out_ready;
    logic [W_OUT-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;

    logic              in_ready_u;
    logic              out_valid_u;
    logic [W_OUT-1:0]  out_data_u;
    logic [TAG_W-1:0]  out_tag_u;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    concat_select_pipe #(.SIGNED_MODE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel_ch    (sel_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    concat_select_pipe #(.SIGNED_MODE(0)) dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_u),
        .in_data   (in_data),
        .sel_ch    (sel_ch),
        .out_valid (out_valid_u),
        .out_ready (out_ready),
        .out_data  (out_data_u),
        .out_tag   (out_tag_u)
    );

    function automatic logic [CH*W-1:0] pack(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                             input logic [W-1:0] c2, input logic [W-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        sel_ch    = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = pack(13'h1, 13'h2, 13'h3, 13'h4);
        sel_ch    = 2'd0;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 24'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 000000", out_data); end
        n_checks++;
        if (out_tag !== 8'h0) begin n_fail++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_signed();
        do_reset();
        in_data  = pack(13'h1000, 13'h0, 13'h0, 13'h0);
        sel_ch   = 2'd0;
        in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL signed_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL signed_early_valid got %b want 0", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL signed_latency got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== 24'h007000) begin n_fail++; $display("FAIL signed_data got %h want 007000", out_data); end
        n_checks++;
        if (out_tag !== 8'd0) begin n_fail++; $display("FAIL signed_tag got %0d want 0", out_tag); end
        n_checks++;
        if (out_data_u !== 24'h005000) begin n_fail++; $display("FAIL unsigned_data got %h want 005000", out_data_u); end
    endtask

    task automatic test_false_branch();
        do_reset();
        in_data  = pack(13'h0, 13'h0120, 13'h1fff, 13'h1fff);
        sel_ch   = 2'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_data !== 24'h00412d) begin n_fail++; $display("FAIL false_data got %h want 00412d", out_data); end
        n_checks++;
        if (out_data_u !== 24'h00412d) begin n_fail++; $display("FAIL false_data_u got %h want 00412d", out_data_u); end
    endtask

    task automatic test_wrap_select();
        do_reset();
        in_data  = pack(13'h0002, 13'h1fff, 13'h0abc, 13'h0);
        sel_ch   = 2'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== 24'h00400f) begin n_fail++; $display("FAIL wrap_data got %h want 00400f", out_data); end
    endtask

    task automatic test_backpressure();
        int sent;
        int got;
        int acc_iter [4];
        int it;
        logic accept;
        logic deliver;
        do_reset();
        out_ready = 1'b0;
        sent = 0;
        got  = 0;
        for (int i = 0; i < 4; i++) acc_iter[i] = -1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = pack(13'(sent + 1), 13'h0, 13'h0, 13'h0);
            sel_ch   = 2'd0;
            accept   = in_valid && in_ready;
            tick();
            if (accept) sent++;
        end
        n_checks++;
        if (sent !== 2) begin n_fail++; $display("FAIL bp_accepted got %0d want 2", sent); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 24'h004001 || out_tag !== 8'd0) begin
                n_fail++;
                $display("FAIL bp_stall_hold got v=%b d=%h t=%0d want v=1 d=004001 t=0",
                         out_valid, out_data, out_tag);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got %b want 1", in_ready); end
        it = 0;
        while (got < 4 && it < 20) begin
            in_valid = (sent < 4);
            in_data  = pack(13'(sent + 1), 13'h0, 13'h0, 13'h0);
            accept   = in_valid && in_ready;
            deliver  = out_valid && out_ready;
            if (deliver) begin
                n_checks++;
                if (out_data !== 24'(24'h004000 + got + 1) || out_tag !== 8'(got)) begin
                    n_fail++;
                    $display("FAIL bp_order item %0d got d=%h t=%0d want d=%h t=%0d",
                             got, out_data, out_tag, 24'(24'h004000 + got + 1), got);
                end
                got++;
            end
            tick();
            if (accept) begin
                acc_iter[sent] = it;
                sent++;
            end
            it++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 4) begin n_fail++; $display("FAIL bp_drain got %0d outputs want 4", got); end
        n_checks++;
        if (acc_iter[2] !== 0 || acc_iter[3] !== 1) begin
            n_fail++;
            $display("FAIL bp_consecutive got cycles %0d,%0d want 0,1", acc_iter[2], acc_iter[3]);
        end
    endtask

    task automatic test_tag_wrap();
        int sent;
        int got;
        int it;
        logic accept;
        logic deliver;
        do_reset();
        out_ready = 1'b1;
        sel_ch    = 2'd0;
        sent = 0;
        got  = 0;
        it   = 0;
        while (got < 257 && it < 400) begin
            in_valid = (sent < 257);
            in_data  = pack(13'(sent + 1), 13'h0, 13'h0, 13'h0);
            accept   = in_valid && in_ready;
            deliver  = out_valid && out_ready;
            if (deliver) begin
                if (got == 255) begin
                    n_checks++;
                    if (out_tag !== 8'd255) begin n_fail++; $display("FAIL tag_255 got %0d want 255", out_tag); end
                end
                if (got == 256) begin
                    n_checks++;
                    if (out_tag !== 8'd0 || out_data !== 24'h004101) begin
                        n_fail++;
                        $display("FAIL tag_wrap got t=%0d d=%h want t=0 d=004101", out_tag, out_data);
                    end
                end
                got++;
            end
            tick();
            if (accept) sent++;
            it++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (it !== 259) begin n_fail++; $display("FAIL throughput got %0d cycles want 259", it); end
    endtask

    task automatic test_mid_reset();
        logic seen;
        do_reset();
        out_ready = 1'b0;
        sel_ch    = 2'd0;
        in_valid  = 1'b1;
        in_data   = pack(13'h5, 13'h0, 13'h0, 13'h0);
        tick();
        in_data   = pack(13'h6, 13'h0, 13'h0, 13'h0);
        tick();
        in_valid  = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight got %b want 1", out_valid); end
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_leak got valid output want none"); end
        in_valid = 1'b1;
        in_data  = pack(13'h7, 13'h0, 13'h0, 13'h0);
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 8'd0 || out_data !== 24'h004007) begin
            n_fail++;
            $display("FAIL midrst_next got v=%b t=%0d d=%h want v=1 t=0 d=004007",
                     out_valid, out_tag, out_data);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        sel_ch    = 2'd0;
        #1;
        test_reset();
        test_signed();
        test_false_branch();
        test_wrap_select();
        test_backpressure();
        test_tag_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
